// File: rtl/deser_pkg.sv
// Shared types and constants for the 8b/10b deserializer sync logic.
package deser_pkg;

    localparam int SYM_W = 9;
    localparam logic [SYM_W-1:0] K28_5 = 9'h1BC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

endpackage

// File: rtl/deser_err_mon.sv
// Leaky error-level counter: bad symbols add one, GOOD_RUN clean symbols remove one.
// limit_hit_o is combinational so the controller can drop lock on the offending symbol.
module deser_err_mon #(
    parameter int ERR_LIMIT = 4,
    parameter int GOOD_RUN  = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       sym_valid_i,
    input  logic       bad_i,
    input  logic       enable_i,
    output logic [3:0] err_level_o,
    output logic       limit_hit_o
);

    localparam logic [3:0] LIMIT_LAST = 4'(ERR_LIMIT - 1);
    localparam logic [7:0] RUN_LAST   = 8'(GOOD_RUN - 1);

    logic [3:0] level_q;
    logic [7:0] run_q;

    // Held at zero outside LOCKED so every lock starts from a clean level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            run_q   <= '0;
        end else if (!enable_i) begin
            level_q <= '0;
            run_q   <= '0;
        end else if (sym_valid_i) begin
            if (bad_i) begin
                level_q <= level_q + 4'd1;
                run_q   <= '0;
            end else if (run_q == RUN_LAST) begin
                run_q <= '0;
                if (level_q != '0) begin
                    level_q <= level_q - 4'd1;
                end
            end else begin
                run_q <= run_q + 8'd1;
            end
        end
    end

    assign err_level_o = level_q;
    assign limit_hit_o = enable_i & sym_valid_i & bad_i & (level_q == LIMIT_LAST);

endmodule

// File: rtl/deser_sync_ctrl.sv
// Comma-alignment / lock controller; all outputs registered, 1 cycle after sym_valid_i.
// No backpressure: every strobe is processed. DESER_SYNC_STATS_EN enables err_cnt_o.
module deser_sync_ctrl
    import deser_pkg::*;
#(
    parameter logic [SYM_W-1:0] COMMA_SYM = K28_5,
    parameter int               LOCK_CNT  = 4,
    parameter int               HUNT_WIN  = 32,
    parameter int               ERR_LIMIT = 4,
    parameter int               GOOD_RUN  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sym_valid_i,
    input  logic [SYM_W-1:0] sym_data_i,
    input  logic             code_err_i,
    input  logic             disp_err_i,
    input  logic             clr_cnt_i,
    output logic             bitslip_o,
    output logic             sync_o,
    output logic [1:0]       state_o,
    output logic [SYM_W-1:0] data_o,
    output logic             data_valid_o,
    output logic [15:0]      err_cnt_o
);

    localparam logic [7:0] WIN_LAST  = 8'(HUNT_WIN - 1);
    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
    localparam logic [3:0] LIMIT     = 4'(ERR_LIMIT);

    sync_state_e      state_q;
    logic [7:0]       win_q;
    logic [3:0]       comma_q;
    logic             bitslip_q;
    logic             sync_q;
    logic [SYM_W-1:0] data_q;
    logic             dvld_q;

    logic       bad;
    logic       comma;
    logic [3:0] err_level;
    logic       limit_hit;

    assign bad   = sym_valid_i & (code_err_i | disp_err_i);
    assign comma = sym_valid_i & ~code_err_i & ~disp_err_i & (sym_data_i == COMMA_SYM);

    deser_err_mon #(
        .ERR_LIMIT (ERR_LIMIT),
        .GOOD_RUN  (GOOD_RUN)
    ) u_err_mon (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sym_valid_i (sym_valid_i),
        .bad_i       (bad),
        .enable_i    (state_q == LOCKED),
        .err_level_o (err_level),
        .limit_hit_o (limit_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= HUNT;
            win_q     <= '0;
            comma_q   <= '0;
            bitslip_q <= 1'b0;
            sync_q    <= 1'b0;
            data_q    <= '0;
            dvld_q    <= 1'b0;
        end else begin
            bitslip_q <= 1'b0;
            dvld_q    <= 1'b0;
            if (sym_valid_i) begin
                // Forwarding looks at the state before this symbol's decision.
                if (state_q == LOCKED) begin
                    data_q <= sym_data_i;
                    dvld_q <= 1'b1;
                end
                case (state_q)
                    HUNT: begin
                        if (comma) begin
                            state_q <= VERIFY;
                            comma_q <= 4'd1;
                            win_q   <= '0;
                        end else if (win_q == WIN_LAST) begin
                            bitslip_q <= 1'b1;
                            win_q     <= '0;
                        end else begin
                            win_q <= win_q + 8'd1;
                        end
                    end
                    VERIFY: begin
                        if (bad) begin
                            state_q <= HUNT;
                            win_q   <= '0;
                        end else if (comma) begin
                            comma_q <= comma_q + 4'd1;
                            if (comma_q == LOCK_LAST) begin
                                state_q <= LOCKED;
                                sync_q  <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (limit_hit) begin
                            state_q <= HUNT;
                            sync_q  <= 1'b0;
                            win_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        sync_q  <= 1'b0;
                        win_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Reaching the limit always exits LOCKED, so a locked level stays below it.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (state_q == LOCKED) |-> (err_level < LIMIT));

`ifdef DESER_SYNC_STATS_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (clr_cnt_i) begin
            err_cnt_q <= '0;
        end else if (bad && (state_q == LOCKED) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic clr_unused;
    assign clr_unused = clr_cnt_i;
    assign err_cnt_o  = 16'h0;
`endif

    assign bitslip_o    = bitslip_q;
    assign sync_o       = sync_q;
    assign state_o      = state_q;
    assign data_o       = data_q;
    assign data_valid_o = dvld_q;

endmodule

// File: tb/tb_deser_sync_ctrl.sv
// Scoreboard bench for deser_sync_ctrl: driver pushes model responses, monitor pops per strobe.
module tb_deser_sync_ctrl;

    localparam int HUNT_WIN  = 32;
    localparam int LOCK_CNT  = 4;
    localparam int ERR_LIMIT = 4;
    localparam int GOOD_RUN  = 16;
    localparam logic [8:0] COMMA = 9'h1BC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sym_valid = 1'b0;
    logic [8:0]  sym_data = '0;
    logic        code_err = 1'b0;
    logic        disp_err = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        bitslip_o;
    logic        sync_o;
    logic [1:0]  state_o;
    logic [8:0]  data_o;
    logic        data_valid_o;
    logic [15:0] err_cnt_o;

    always #5 clk = ~clk;

    deser_sync_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .sym_valid_i  (sym_valid),
        .sym_data_i   (sym_data),
        .code_err_i   (code_err),
        .disp_err_i   (disp_err),
        .clr_cnt_i    (clr_cnt),
        .bitslip_o    (bitslip_o),
        .sync_o       (sync_o),
        .state_o      (state_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .err_cnt_o    (err_cnt_o)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        sync;
        logic        slip;
        logic        dvld;
        logic [8:0]  data;
        logic [15:0] ec;
    } resp_t;

    resp_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    slip_seen = 0;
    logic  strobe_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: link mode, symbols since last slip/restart, commas seen, leaky level.
    int         m_mode, m_since, m_commas, m_lvl, m_run, m_ec;
    logic [8:0] m_last;

    function automatic void model_reset();
        m_mode = 0; m_since = 0; m_commas = 0; m_lvl = 0; m_run = 0; m_ec = 0;
        m_last = '0;
    endfunction

    function automatic resp_t model_step(input logic [8:0] d, input logic ce,
                                         input logic de, input logic clr);
        resp_t r;
        bit    is_bad;
        bit    is_comma;
        is_bad   = ce || de;
        is_comma = !is_bad && (d == COMMA);
        r        = '0;
        r.dvld   = (m_mode == 2);
        if (m_mode == 2) m_last = d;
`ifdef DESER_SYNC_STATS_EN
        if (m_mode == 2 && is_bad && m_ec < 65535) m_ec++;
        if (clr) m_ec = 0;
`else
        if (clr) m_ec = 0;
`endif
        if (m_mode == 0) begin
            if (is_comma) begin
                m_mode = 1; m_commas = 1; m_since = 0;
            end else begin
                m_since++;
                if (m_since == HUNT_WIN) begin
                    r.slip = 1'b1; m_since = 0;
                end
            end
        end else if (m_mode == 1) begin
            if (is_bad) begin
                m_mode = 0; m_since = 0;
            end else if (is_comma) begin
                m_commas++;
                if (m_commas == LOCK_CNT) begin
                    m_mode = 2; m_lvl = 0; m_run = 0;
                end
            end
        end else begin
            if (is_bad) begin
                m_lvl++; m_run = 0;
                if (m_lvl >= ERR_LIMIT) begin
                    m_mode = 0; m_since = 0;
                end
            end else begin
                m_run++;
                if (m_run == GOOD_RUN) begin
                    m_run = 0;
                    if (m_lvl > 0) m_lvl--;
                end
            end
        end
        r.st   = 2'(m_mode);
        r.sync = (m_mode == 2);
        r.data = m_last;
        r.ec   = 16'(m_ec);
        return r;
    endfunction

    always @(posedge clk) strobe_seen <= sym_valid && rst_n;

    // Monitor: a response is due the cycle after every strobe; otherwise strobes must be quiet.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bitslip_o) slip_seen++;
            if (strobe_seen) begin
                if (exp_q.size() == 0) begin
                    chk("resp_queue_empty", 32'(exp_q.size()), 1);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("state_o", 32'(state_o), 32'(e.st));
                    chk("sync_o", 32'(sync_o), 32'(e.sync));
                    chk("bitslip_o", 32'(bitslip_o), 32'(e.slip));
                    chk("data_valid_o", 32'(data_valid_o), 32'(e.dvld));
                    chk("data_o", 32'(data_o), 32'(e.data));
                    chk("err_cnt_o", 32'(err_cnt_o), 32'(e.ec));
                end
            end else begin
                chk("idle_bitslip", 32'(bitslip_o), 0);
                chk("idle_dvalid", 32'(data_valid_o), 0);
            end
        end
    end

    task automatic send(input logic [8:0] d, input logic ce, input logic de, input logic clr);
        @(negedge clk);
        sym_valid = 1'b1; sym_data = d; code_err = ce; disp_err = de; clr_cnt = clr;
        exp_q.push_back(model_step(d, ce, de, clr));
        @(negedge clk);
        sym_valid = 1'b0; code_err = 1'b0; disp_err = 1'b0; clr_cnt = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic good(input logic [8:0] d, input int n);
        for (int i = 0; i < n; i++) send(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lock_up();
        for (int i = 0; i < LOCK_CNT; i++) begin
            send(COMMA, 1'b0, 1'b0, 1'b0);
            send(9'h0AA, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic reset_checks(input string tag);
        exp_q.delete();
        model_reset();
        sym_valid = 1'b0; code_err = 1'b0; disp_err = 1'b0; clr_cnt = 1'b0;
        #1;
        chk({tag, "_state"}, 32'(state_o), 0);
        chk({tag, "_sync"}, 32'(sync_o), 0);
        chk({tag, "_bitslip"}, 32'(bitslip_o), 0);
        chk({tag, "_dvalid"}, 32'(data_valid_o), 0);
        chk({tag, "_data"}, 32'(data_o), 0);
        chk({tag, "_errcnt"}, 32'(err_cnt_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_first_bitslip"}, 32'(bitslip_o), 0);
        chk({tag, "_first_state"}, 32'(state_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        model_reset();
        #12;
        reset_checks("por");

        // Pure hunt: one slip per HUNT_WIN symbols.
        s0 = slip_seen;
        good(9'h0AA, 32);
        chk("slips_after_32", 32'(slip_seen - s0), 1);
        good(9'h0AA, 32);
        chk("slips_after_64", 32'(slip_seen - s0), 2);

        // Lock on interleaved commas, then forward 9'h055.
        lock_up();
        chk("locked_sync", 32'(sync_o), 1);
        send(9'h055, 1'b0, 1'b0, 1'b0);
        chk("first_fwd_data", 32'(data_o), 32'h055);

        // Four bad symbols three good apart drop lock.
        for (int k = 0; k < 4; k++) begin
            send(9'h033, 1'b1, 1'b0, 1'b0);
            if (k < 3) good(9'h011, 3);
        end
        chk("lost_sync", 32'(sync_o), 0);

        // VERIFY abort, then window restarts from zero.
        good(COMMA, 2);
        send(9'h0AA, 1'b1, 1'b0, 1'b0);
        s0 = slip_seen;
        good(9'h0AA, 31);
        chk("no_slip_31", 32'(slip_seen - s0), 0);
        good(9'h0AA, 1);
        chk("slip_at_32", 32'(slip_seen - s0), 1);

        // Leaky counter boundary: 15 good between bad loses lock.
        lock_up();
        for (int k = 0; k < 4; k++) begin
            send(9'h044, 1'b0, 1'b1, 1'b0);
            if (k < 3) good(9'h022, 15);
        end
        chk("run15_lost", 32'(sync_o), 0);

        // 16 good between bad holds lock; clear coinciding with a bad symbol wins.
        lock_up();
        for (int k = 0; k < 5; k++) begin
            send(9'h044, 1'b1, 1'b1, 1'b0);
            good(9'h022, 16);
        end
        chk("run16_held", 32'(sync_o), 1);
        send(9'h066, 1'b1, 1'b0, 1'b1);
        chk("clr_wins", 32'(err_cnt_o), 0);

        // Reset mid-VERIFY.
        good(9'h0AA, 40);
        for (int k = 0; k < 4; k++) send(9'h000, 1'b1, 1'b0, 1'b0);
        good(COMMA, 2);
        chk("pre_rst_verify", 32'(state_o), 1);
        @(negedge clk); #2 rst_n = 1'b0;
        reset_checks("rst_verify");

        // Reset while bitslip_o is high.
        good(9'h0AA, 31);
        @(negedge clk);
        sym_valid = 1'b1; sym_data = 9'h0AA;
        exp_q.push_back(model_step(9'h0AA, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        chk("pre_rst_slip", 32'(bitslip_o), 1);
        rst_n = 1'b0;
        reset_checks("rst_slip");

        // Randomised traffic against the model.
        for (int i = 0; i < 1400; i++) begin
            logic [8:0] d;
            logic ce, de, cl;
            d  = ($urandom_range(0, 99) < 35) ? COMMA : 9'($urandom);
            ce = ($urandom_range(0, 99) < 4);
            de = ($urandom_range(0, 99) < 2);
            cl = ($urandom_range(0, 99) < 3);
            send(d, ce, de, cl);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/deser_sync_ctrl.md
# deser_sync_ctrl

Link-synchronisation controller for the 8b/10b deserializer. It watches the decoded symbol stream, the per-symbol code and disparity error flags, and the end-of-block strobe. It finds comma alignment by requesting single-bit slips, declares lock after repeated aligned commas, and drops lock when errors accumulate. It sits between the deserializer and the downstream framing logic, and it gates data so that only symbols received in lock are forwarded.

## Interface
- COMMA_SYM, 9'h1BC: alignment symbol in decoder format (bit 8 = K flag; default K28.5).
- LOCK_CNT, 4: consecutive error-free commas required to enter LOCKED; range 2..15.
- HUNT_WIN, 32: symbols searched without a comma before a bitslip is issued; range 2..255.
- ERR_LIMIT, 4: error level that forces loss of sync; range 1..15.
- GOOD_RUN, 16: consecutive good symbols that decrement the error level by 1; range 1..255.
- clk_i  in  1  system clock, single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- sym_valid_i  in  1  one-cycle strobe; a decoded symbol is present (deserializer end-of-block).
- sym_data_i  in  9  decoded symbol {K, data[7:0]}.
- code_err_i  in  1  code error for the current symbol.
- disp_err_i  in  1  disparity error for the current symbol.
- clr_cnt_i  in  1  synchronous clear of err_cnt_o.
- bitslip_o  out  1  one-cycle request that the deserializer drop one serial bit.
- sync_o  out  1  high while in LOCKED.
- state_o  out  2  current state: HUNT=0, VERIFY=1, LOCKED=2.
- data_o  out  9  forwarded symbol.
- data_valid_o  out  1  one-cycle strobe with data_o.
- err_cnt_o  out  16  saturating count of bad symbols seen while LOCKED.

## Operation
- Bad symbol: code_err_i or disp_err_i high while sym_valid_i is high. Comma: sym_data_i == COMMA_SYM with no error.
- All decisions occur only on cycles with sym_valid_i high; all other cycles hold state.
- HUNT: the window counter increments per symbol. A comma moves to VERIFY with comma count = 1. When the window counter reaches HUNT_WIN-1 without a comma, bitslip_o pulses and the counter clears.
- VERIFY: each comma increments the comma count. When the count reaches LOCK_CNT, the state moves to LOCKED and the error level clears. A bad symbol returns to HUNT and clears the window counter. Non-comma good symbols are neutral.
- LOCKED: each bad symbol increments the error level and clears the good-run counter. GOOD_RUN consecutive good symbols decrement the error level (floor 0) and restart the run. When the error level reaches ERR_LIMIT, the state moves to HUNT.
- Forwarding: data_o/data_valid_o fire for every symbol accepted while state is LOCKED, including bad ones. The symbol that causes the LOCKED entry is not forwarded; the symbol that causes the exit is forwarded.
- err_cnt_o increments on each bad symbol in LOCKED and saturates at 16'hFFFF. If clr_cnt_i coincides with an increment, clear wins and the result is 0.
- Reset (asynchronous, at any point including mid-hunt or mid-slip): state HUNT, all counters 0, bitslip_o 0, sync_o 0, data_o 0, data_valid_o 0, err_cnt_o 0.

## Timing
- All outputs are registered.
- Latency from sym_valid_i to data_valid_o, state_o, sync_o and bitslip_o is 1 cycle.
- bitslip_o is high for exactly one cycle per slip. No second slip is issued until HUNT_WIN further symbols have been received.
- The deserializer strobes at most once every 10 cycles, so back-to-back strobes need not be handled. Behaviour on consecutive-cycle strobes is still deterministic: each strobe is processed.

## Configuration
- DESER_SYNC_STATS_EN defined: the err_cnt_o counter and clr_cnt_i logic are present.
- DESER_SYNC_STATS_EN undefined: err_cnt_o is tied to 16'h0 and clr_cnt_i is ignored. Sync behaviour is identical in both cases.

## Structure
- Shared package deser_pkg holds:
  - the state enum sync_state_e (2-bit: HUNT, VERIFY, LOCKED);
  - the constant K28_5 = 9'h1BC;
  - the symbol width constant SYM_W = 9.
- One sub-module, deser_err_mon, holds the error-level / good-run leaky counter. Its inputs are sym_valid, bad and enable; its outputs are err_level and limit_hit. The FSM, window counter, comma counter and forwarding logic stay in the top module.

## Test plan
- Reset mid-VERIFY, then release: state_o=0, sync_o=0, err_cnt_o=0, and no bitslip_o on the first cycle.
- Stream of 32 symbols of 9'h0AA: exactly one bitslip_o pulse, 1 cycle after the 32nd strobe. After 64 symbols, exactly 2 pulses.
- 4 commas 9'h1BC interleaved with data, no errors: sync_o rises 1 cycle after the 4th comma. The next data symbol 9'h055 appears on data_o with data_valid_o.
- VERIFY with 2 commas, then a symbol with code_err_i=1: state_o returns to 0, and the window counter restarts from 0.
- LOCKED with 4 bad symbols separated by 3 good symbols each: sync_o falls after the 4th bad symbol, and err_cnt_o=4 (with DESER_SYNC_STATS_EN).
- LOCKED with 15 good symbols between bad ones: the level reaches 4 and lock is lost. With exactly 16 good symbols between bad ones, the level stays at 1 and lock is held. Assert clr_cnt_i together with a bad symbol: err_cnt_o becomes 0.
